// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction memory and fills IF/ID.
// Optional performance counters (FetchCount, StallCount) are built when IF_FETCH_PERF_EN is defined.
module if_fetch_unit #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       INSTR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] IMEM_LAST = ADDR_W'(225)
) (
    input  logic               CLK,
    input  logic               Reset_n,
    output logic [ADDR_W-1:0]  IMAddress,
    input  logic [INSTR_W-1:0] IMData,
    input  logic               Stall,
    input  logic               BranchTaken,
    input  logic [ADDR_W-1:0]  BranchTarget,
    output logic [ADDR_W-1:0]  IF_ID_PC,
    output logic [INSTR_W-1:0] IF_ID_Instr,
    output logic               IF_ID_Valid,
    output logic               Fault
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]        FetchCount,
    output logic [31:0]        StallCount
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   pc, pc_next;
    logic [ADDR_W-1:0]   id_pc_next;
    logic [INSTR_W-1:0]  id_instr_next;
    logic                id_valid_next;
    logic                fault_next;
    logic                target_ok;
    logic                pc_fetch_ok;

    // A word is fetchable only if all four of its bytes lie inside the memory;
    // the extra top bit makes an overflowing address+3 count as out of range.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] last_byte;
        last_byte = {1'b0, addr} + (ADDR_W+1)'(3);
        return last_byte <= {1'b0, IMEM_LAST};
    endfunction

    assign target_ok   = (BranchTarget[1:0] == 2'b00) && in_range(BranchTarget);
    assign pc_fetch_ok = in_range(pc);
    assign IMAddress   = pc;

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        id_pc_next    = IF_ID_PC;
        id_instr_next = IF_ID_Instr;
        id_valid_next = IF_ID_Valid;
        fault_next    = Fault;

        case (state)
            ST_BOOT: begin
                id_valid_next = 1'b0;
                state_next    = ST_RUN;
            end

            ST_RUN: begin
                if (BranchTaken) begin
                    pc_next       = BranchTarget;
                    id_valid_next = 1'b0;
                    if (!target_ok) begin
                        fault_next = 1'b1;
                        state_next = ST_HALT;
                    end
                end else if (Stall) begin
                    // hold everything
                end else if (!pc_fetch_ok) begin
                    fault_next    = 1'b1;
                    id_valid_next = 1'b0;
                    state_next    = ST_HALT;
                end else begin
                    id_pc_next    = pc;
                    id_instr_next = IMData;
                    id_valid_next = 1'b1;
                    pc_next       = pc + ADDR_W'(4);
                end
            end

            ST_HALT: begin
                id_valid_next = 1'b0;
                // Only a usable redirect leaves HALT; Stall is irrelevant here.
                if (BranchTaken && target_ok) begin
                    pc_next    = BranchTarget;
                    fault_next = 1'b0;
                    state_next = ST_RUN;
                end
            end

            default: begin
                id_valid_next = 1'b0;
                state_next    = ST_BOOT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            IF_ID_PC    <= '0;
            IF_ID_Instr <= '0;
            IF_ID_Valid <= 1'b0;
            Fault       <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            IF_ID_PC    <= id_pc_next;
            IF_ID_Instr <= id_instr_next;
            IF_ID_Valid <= id_valid_next;
            Fault       <= fault_next;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic capture;
    logic stall_cycle;

    assign capture     = (state == ST_RUN) && !BranchTaken && !Stall && pc_fetch_ok;
    assign stall_cycle = (state == ST_RUN) && !BranchTaken && Stall;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            if (capture && (FetchCount != 32'hFFFF_FFFF)) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (stall_cycle && (StallCount != 32'hFFFF_FFFF)) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, async reset sequence,
// and randomized traffic against a behavioural model of the fetch rules.
module tb_if_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic [63:0] IMAddress;
    logic [31:0] IMData;
    logic        Stall;
    logic        BranchTaken;
    logic [63:0] BranchTarget;
    logic [63:0] IF_ID_PC;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    logic        Fault;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
`endif

    int checks   = 0;
    int failures = 0;

    if_fetch_unit dut (
        .CLK          (CLK),
        .Reset_n      (Reset_n),
        .IMAddress    (IMAddress),
        .IMData       (IMData),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .IF_ID_PC     (IF_ID_PC),
        .IF_ID_Instr  (IF_ID_Instr),
        .IF_ID_Valid  (IF_ID_Valid),
        .Fault        (Fault)
`ifdef IF_FETCH_PERF_EN
        ,
        .FetchCount   (FetchCount),
        .StallCount   (StallCount)
`endif
    );

    always #5 CLK = ~CLK;

    // Big-endian byte memory, 226 valid bytes; reads beyond the last full word return a marker.
    logic [7:0] mem [0:255];
    logic [7:0] ia;
    assign ia     = IMAddress[7:0];
    assign IMData = (IMAddress <= 64'd222) ?
                    {mem[ia], mem[ia + 8'd1], mem[ia + 8'd2], mem[ia + 8'd3]} : 32'hDEAD_BEEF;

    task automatic put_word(input int addr, input logic [31:0] w);
        mem[addr]     = w[31:24];
        mem[addr + 1] = w[23:16];
        mem[addr + 2] = w[15:8];
        mem[addr + 3] = w[7:0];
    endtask

    function automatic logic [31:0] word_at(input logic [63:0] a);
        int b;
        b = int'(a[7:0]);
        return {mem[b], mem[b + 1], mem[b + 2], mem[b + 3]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_pc, m_id_pc;
    logic [31:0] m_instr;
    bit          m_valid, m_fault, m_boot;
    longint      m_fetch, m_stall;

    function automatic bit fits(input logic [63:0] a);
        logic [64:0] e;
        e = {1'b0, a} + 65'd3;
        return e <= 65'd225;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_id_pc = 0; m_instr = 0;
        m_valid = 0; m_fault = 0; m_boot = 1;
        m_fetch = 0; m_stall = 0;
    endtask

    // The fault flag doubles as "halted": a faulted unit only waits for a usable redirect.
    task automatic model_step(input bit s, input bit b, input logic [63:0] t);
        bit t_ok;
        t_ok = (t[1:0] == 2'b00) && fits(t);
        if (m_boot) begin
            m_boot = 0;
        end else if (m_fault) begin
            if (b && t_ok) begin
                m_pc = t;
                m_fault = 0;
            end
        end else if (b) begin
            m_pc = t;
            m_valid = 0;
            if (!t_ok) m_fault = 1;
        end else if (s) begin
            if (m_stall < 64'hFFFF_FFFF) m_stall++;
        end else if (!fits(m_pc)) begin
            m_fault = 1;
            m_valid = 0;
        end else begin
            m_id_pc = m_pc;
            m_instr = word_at(m_pc);
            m_valid = 1;
            m_pc    = m_pc + 64'd4;
            if (m_fetch < 64'hFFFF_FFFF) m_fetch++;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_imaddr"}, IMAddress, m_pc);
        check({tag, "_valid"}, 64'(IF_ID_Valid), 64'(m_valid));
        check({tag, "_fault"}, 64'(Fault), 64'(m_fault));
        if (m_valid) begin
            check({tag, "_idpc"}, IF_ID_PC, m_id_pc);
            check({tag, "_instr"}, 64'(IF_ID_Instr), 64'(m_instr));
        end
`ifdef IF_FETCH_PERF_EN
        check({tag, "_fetchcnt"}, 64'(FetchCount), 64'(m_fetch));
        check({tag, "_stallcnt"}, 64'(StallCount), 64'(m_stall));
`endif
    endtask

    // Inputs are driven just after an edge, the model advances, then outputs are sampled 1 ns after the next edge.
    task automatic step(input bit s, input bit b, input logic [63:0] t);
        Stall        = s;
        BranchTaken  = b;
        BranchTarget = t;
        model_step(s, b, t);
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        Stall = 0; BranchTaken = 0; BranchTarget = 0;
        Reset_n = 1'b0;
        repeat (2) @(posedge CLK);
        #3 Reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          stall;
        bit          br;
        logic [63:0] tgt;
        logic [63:0] pc;
        logic [63:0] id_pc;
        logic [31:0] instr;
        bit          valid;
        bit          fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit s, input bit b, input logic [63:0] t, input logic [63:0] pc,
                       input logic [63:0] idpc, input logic [31:0] ins, input bit v, input bit f);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.pc = pc;
        r.id_pc = idpc; r.instr = ins; r.valid = v; r.fault = f;
        vecs.push_back(r);
    endtask

    initial begin
        Reset_n = 1'b0;
        Stall = 0; BranchTaken = 0; BranchTarget = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        put_word(0,   32'hF842_8005);
        put_word(4,   32'hF845_000A);
        put_word(8,   32'h8A0A_00A1);
        put_word(32,  32'h1234_5678);
        put_word(216, 32'hCAFE_0216);
        put_word(220, 32'hCAFE_0220);

        //   stall br  tgt  pc   id_pc  instr          v  f
        add(0, 0, 0,   0,   0,   32'h0,          0, 0); // BOOT cycle
        add(0, 0, 0,   4,   0,   32'hF842_8005, 1, 0);
        add(0, 0, 0,   8,   4,   32'hF845_000A, 1, 0);
        add(1, 0, 0,   8,   4,   32'hF845_000A, 1, 0); // stall x3 at PC 8
        add(1, 0, 0,   8,   4,   32'hF845_000A, 1, 0);
        add(1, 0, 0,   8,   4,   32'hF845_000A, 1, 0);
        add(0, 0, 0,   12,  8,   32'h8A0A_00A1, 1, 0);
        add(1, 1, 32,  32,  8,   32'h8A0A_00A1, 0, 0); // branch beats stall
        add(0, 0, 0,   36,  32,  32'h1234_5678, 1, 0);
        add(0, 1, 216, 216, 32,  32'h1234_5678, 0, 0);
        add(0, 0, 0,   220, 216, 32'hCAFE_0216, 1, 0);
        add(0, 0, 0,   224, 220, 32'hCAFE_0220, 1, 0);
        add(0, 0, 0,   224, 220, 32'hCAFE_0220, 0, 1); // 224+3 > 225
        add(0, 0, 0,   224, 220, 32'hCAFE_0220, 0, 1);
        add(0, 1, 0,   0,   220, 32'hCAFE_0220, 0, 0); // recover
        add(0, 0, 0,   4,   0,   32'hF842_8005, 1, 0);
        add(0, 1, 6,   6,   0,   32'hF842_8005, 0, 1); // misaligned
        add(1, 0, 0,   6,   0,   32'hF842_8005, 0, 1);
        add(0, 0, 0,   6,   0,   32'hF842_8005, 0, 1);
        add(0, 1, 224, 6,   0,   32'hF842_8005, 0, 1); // bad target in HALT

        apply_reset();
        check("rst_imaddr", IMAddress, 64'd0);
        check("rst_valid",  64'(IF_ID_Valid), 64'd0);
        check("rst_fault",  64'(Fault), 64'd0);
        check("rst_idpc",   IF_ID_PC, 64'd0);
        check("rst_instr",  64'(IF_ID_Instr), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].stall, vecs[i].br, vecs[i].tgt);
            check($sformatf("row%0d_imaddr", i), IMAddress, vecs[i].pc);
            check($sformatf("row%0d_idpc", i),   IF_ID_PC, vecs[i].id_pc);
            check($sformatf("row%0d_instr", i),  64'(IF_ID_Instr), 64'(vecs[i].instr));
            check($sformatf("row%0d_valid", i),  64'(IF_ID_Valid), 64'(vecs[i].valid));
            check($sformatf("row%0d_fault", i),  64'(Fault), 64'(vecs[i].fault));
        end

        // ---- asynchronous reset in mid-stream ----
        apply_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        check("pre_areset_pc", IMAddress, 64'd20);
        #3 Reset_n = 1'b0;
        #1;
        check("areset_imaddr", IMAddress, 64'd0);
        check("areset_valid",  64'(IF_ID_Valid), 64'd0);
        check("areset_fault",  64'(Fault), 64'd0);
        check("areset_idpc",   IF_ID_PC, 64'd0);
        check("areset_instr",  64'(IF_ID_Instr), 64'd0);
`ifdef IF_FETCH_PERF_EN
        check("areset_fetchcnt", 64'(FetchCount), 64'd0);
        check("areset_stallcnt", 64'(StallCount), 64'd0);
`endif
        @(posedge CLK);
        #3 Reset_n = 1'b1;
        model_reset();
        step(0, 0, 0);
        check("post_boot_valid", 64'(IF_ID_Valid), 64'd0);
        check("post_boot_pc",    IMAddress, 64'd0);
        step(0, 0, 0);
        check("resume_idpc",  IF_ID_PC, 64'd0);
        check("resume_valid", 64'(IF_ID_Valid), 64'd1);
        check("resume_instr", 64'(IF_ID_Instr), 64'hF842_8005);

        // ---- randomized traffic against the model ----
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            bit          s, b;
            logic [63:0] t;
            int          pick;
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 8);
            pick = $urandom_range(0, 9);
            if (pick < 7)       t = 64'($urandom_range(0, 55)) * 64'd4;
            else if (pick == 7) t = 64'($urandom_range(0, 55)) * 64'd4 + 64'($urandom_range(1, 3));
            else if (pick == 8) t = 64'd224 + 64'($urandom_range(0, 1)) * 64'd4;
            else                t = 64'hFFFF_FFFF_FFFF_FFFC;
            step(s, b, t);
            compare_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
